// File: rtl/action_menu_if.sv
`default_nettype none
// ============================================================================
// Module   : action_menu_if
// Purpose  : Pixel, keyboard and font-ROM signal bundle for action_menu_display.
// Revision : 1.0
// ============================================================================
interface action_menu_if #(
   parameter int NUM_BUTTONS = 3
);
   logic                   frame_start;
   logic [9:0]             DrawX;
   logic [9:0]             DrawY;
   logic                   if_BetCheck;
   logic [NUM_BUTTONS-1:0] btn_enable;
   logic                   key_up;
   logic                   key_down;
   logic                   key_select;
   logic [7:0]             font_data;
   logic [10:0]            font_address;
   logic                   text_on;
   logic                   highlight_on;
   logic [1:0]             sel_index;
   logic                   action_valid;
   logic [2:0]             action_code;

   modport master (
      output frame_start, DrawX, DrawY, if_BetCheck, btn_enable,
      output key_up, key_down, key_select, font_data,
      input  font_address, text_on, highlight_on, sel_index,
      input  action_valid, action_code
   );

   modport slave (
      input  frame_start, DrawX, DrawY, if_BetCheck, btn_enable,
      input  key_up, key_down, key_select, font_data,
      output font_address, text_on, highlight_on, sel_index,
      output action_valid, action_code
   );
endinterface
`default_nettype wire

// File: rtl/action_menu_display.sv
`default_nettype none
// ============================================================================
// Module   : action_menu_display
// Purpose  : NUM_BUTTONS labelled action rows with a keyboard selection cursor,
//            font-ROM latency alignment and a one-cycle action strobe.
//            Optional macro MENU_BLINK_EN blinks the selected row.
// Revision : 1.0
// ============================================================================
module action_menu_display #(
   parameter int NUM_BUTTONS  = 3,
   parameter int X_START      = 540,
   parameter int ROW_Y0       = 350,
   parameter int ROW_PITCH    = 46,
   parameter int CHARS        = 9,
   parameter int FONT_LATENCY = 1
) (
   input  wire logic    Clk,
   input  wire logic    Reset,
   action_menu_if.slave bus
);

   localparam logic [11:0] c_x_lo = 12'(X_START);
   localparam logic [11:0] c_x_hi = 12'(X_START + 8 * CHARS);

   logic [11:0] w_x;
   logic [11:0] w_y;
   logic [11:0] w_dx;
   logic        w_in_x;
   logic        w_hit;
   logic [1:0]  w_row;
   logic [3:0]  w_gy;
   logic [8:0]  w_ci;
   logic [2:0]  w_fx;
   logic [7:0]  w_char;
   logic [10:0] w_addr;
   logic        w_any_en;
   logic        w_sel_row;

   logic        w_hit_d;
   logic        w_sel_d;
   logic [2:0]  w_fx_d;
   logic        w_font_bit;
   logic        w_blink;

   logic [1:0]  r_sel;
   logic        r_av;
   logic [2:0]  r_ac;
   logic [1:0]  w_sel_nxt;
   logic [1:0]  w_dn_idx;
   logic [1:0]  w_up_idx;
   logic        w_cur_en;
   logic        w_sel_acc;
   logic        w_mv_up;
   logic        w_mv_dn;

   function automatic logic [7:0] label_char(input logic [1:0] row,
                                             input logic [8:0] idx,
                                             input logic       bc);
      logic [71:0] s;
      logic [7:0]  c;
      case (row)
         2'd0:    s = bc ? "[B] BET  " : "[R] RAISE";
         2'd1:    s = bc ? "[C] CHECK" : "[C] CALL ";
         2'd2:    s = "[F] FOLD ";
         default: s = "[A] ALLIN";
      endcase
      c = 8'h20;
      for (int i = 0; i < 9; i++) begin
         if (idx == 9'(i)) c = s[8*(8-i) +: 8];
      end
      return c;
   endfunction

   assign w_x    = {2'b00, bus.DrawX};
   assign w_y    = {2'b00, bus.DrawY};
   assign w_dx   = w_x - c_x_lo;
   assign w_in_x = (w_x >= c_x_lo) && (w_x < c_x_hi);
   assign w_fx   = w_dx[2:0];
   assign w_ci   = (w_dx[11:3] >= 9'(CHARS)) ? 9'd0 : w_dx[11:3];

   // Rows never overlap because the pitch is at least one glyph tall.
   always_comb begin
      w_hit = 1'b0;
      w_row = 2'd0;
      w_gy  = 4'd0;
      for (int r = 0; r < NUM_BUTTONS; r++) begin
         if (w_in_x &&
             (w_y >= 12'(ROW_Y0 + r * ROW_PITCH)) &&
             (w_y <  12'(ROW_Y0 + r * ROW_PITCH + 16))) begin
            w_hit = 1'b1;
            w_row = 2'(r);
            w_gy  = 4'(w_y - 12'(ROW_Y0 + r * ROW_PITCH));
         end
      end
   end

   assign w_char    = label_char(w_row, w_ci, bus.if_BetCheck);
   assign w_addr    = w_hit ? 11'({w_char, w_gy}) : 11'd0;
   assign w_any_en  = |bus.btn_enable;
   assign w_sel_row = w_hit && (w_row == r_sel) && w_any_en;

   generate
      if (FONT_LATENCY == 0) begin : g_lat0
         assign w_hit_d = w_hit;
         assign w_sel_d = w_sel_row;
         assign w_fx_d  = w_fx;
      end else begin : g_latn
         logic [FONT_LATENCY-1:0]      r_hit_q;
         logic [FONT_LATENCY-1:0]      r_sel_q;
         logic [FONT_LATENCY-1:0][2:0] r_fx_q;

         always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
               r_hit_q <= '0;
               r_sel_q <= '0;
               r_fx_q  <= '0;
            end else begin
               r_hit_q[0] <= w_hit;
               r_sel_q[0] <= w_sel_row;
               r_fx_q[0]  <= w_fx;
               for (int i = 1; i < FONT_LATENCY; i++) begin
                  r_hit_q[i] <= r_hit_q[i-1];
                  r_sel_q[i] <= r_sel_q[i-1];
                  r_fx_q[i]  <= r_fx_q[i-1];
               end
            end
         end

         assign w_hit_d = r_hit_q[FONT_LATENCY-1];
         assign w_sel_d = r_sel_q[FONT_LATENCY-1];
         assign w_fx_d  = r_fx_q[FONT_LATENCY-1];
      end
   endgenerate

   assign w_font_bit       = bus.font_data[3'd7 - w_fx_d];
   assign bus.font_address = Reset ? 11'd0 : w_addr;
   assign bus.text_on      = ~Reset & w_hit_d & (w_font_bit ^ (w_blink & w_sel_d));
   assign bus.highlight_on = ~Reset & w_hit_d & w_sel_d & ~w_blink;

   always_comb begin
      w_cur_en = 1'b0;
      for (int j = 0; j < NUM_BUTTONS; j++) begin
         if (r_sel == 2'(j)) w_cur_en = bus.btn_enable[j];
      end
   end

   // Descending distance so the nearest enabled row is the last one written.
   always_comb begin
      w_dn_idx = r_sel;
      w_up_idx = r_sel;
      for (int k = NUM_BUTTONS - 1; k >= 1; k--) begin
         for (int j = 0; j < NUM_BUTTONS; j++) begin
            if ((j == (int'(r_sel) + k) % NUM_BUTTONS) && bus.btn_enable[j])
               w_dn_idx = 2'(j);
            if ((j == (int'(r_sel) + NUM_BUTTONS - k) % NUM_BUTTONS) && bus.btn_enable[j])
               w_up_idx = 2'(j);
         end
      end
   end

   assign w_sel_acc = bus.key_select & w_cur_en;
   assign w_mv_up   = ~bus.key_select & bus.key_up   & ~bus.key_down;
   assign w_mv_dn   = ~bus.key_select & bus.key_down & ~bus.key_up;

   always_comb begin
      w_sel_nxt = r_sel;
      if (w_mv_up)
         w_sel_nxt = w_up_idx;
      else if (w_mv_dn)
         w_sel_nxt = w_dn_idx;
      else if (bus.frame_start && !w_cur_en)
         w_sel_nxt = w_dn_idx;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sel <= 2'd0;
         r_av  <= 1'b0;
         r_ac  <= 3'd0;
      end else begin
         r_sel <= w_sel_nxt;
         r_av  <= w_sel_acc;
         if (w_sel_acc) r_ac <= {bus.if_BetCheck, r_sel};
      end
   end

`ifdef MENU_BLINK_EN
   logic [4:0] r_blink_cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         r_blink_cnt <= 5'd0;
      else if (w_sel_acc || w_mv_up || w_mv_dn)
         r_blink_cnt <= 5'd0;
      else if (bus.frame_start)
         r_blink_cnt <= r_blink_cnt + 5'd1;
   end

   assign w_blink = r_blink_cnt[4];
`else
   assign w_blink = 1'b0;
`endif

   assign bus.sel_index    = r_sel;
   assign bus.action_valid = r_av;
   assign bus.action_code  = r_ac;

endmodule
`default_nettype wire

// File: tb/tb_action_menu_display.sv
`default_nettype none
// Bench for action_menu_display: vector table, corner-case sequences and a
// randomized run against a behavioural model of the menu.
module tb_action_menu_display;
   localparam int NB = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   action_menu_if #(.NUM_BUTTONS(NB)) bus ();

   action_menu_display #(
      .NUM_BUTTONS (NB),
      .X_START     (540),
      .ROW_Y0      (350),
      .ROW_PITCH   (46),
      .CHARS       (9),
      .FONT_LATENCY(1)
   ) dut (
      .Clk  (clk),
      .Reset(rst),
      .bus  (bus)
   );

   typedef struct {
      int         x;
      int         y;
      bit         bc;
      logic [7:0] fd;
      int         addr;
      bit         txt;
      bit         hl;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit u, input bit d, input bit s);
      bus.key_up     = u;
      bus.key_down   = d;
      bus.key_select = s;
      cyc();
      bus.key_up     = 1'b0;
      bus.key_down   = 1'b0;
      bus.key_select = 1'b0;
      #2;
   endtask

   function automatic int ref_char(input int row, input int idx, input bit bc);
      string s;
      case (row)
         0:       s = bc ? "[B] BET  " : "[R] RAISE";
         1:       s = bc ? "[C] CHECK" : "[C] CALL ";
         2:       s = "[F] FOLD ";
         default: s = "[A] ALLIN";
      endcase
      return int'(s[idx]);
   endfunction

   function automatic void ref_pixel(input int x, input int y, input bit bc,
                                     output bit hit, output int row,
                                     output int addr, output int fx);
      int top, idx;
      hit = 0; row = 0; addr = 0; fx = 0;
      for (int r = 0; r < NB; r++) begin
         top = 350 + r * 46;
         if (y >= top && y < top + 16 && x >= 540 && x < 540 + 8 * 9) begin
            hit  = 1;
            row  = r;
            idx  = (x - 540) / 8;
            if (idx >= 9) idx = 0;
            addr = ref_char(r, idx, bc) * 16 + (y - top);
            fx   = (x - 540) % 8;
         end
      end
   endfunction

   // Next enabled row above/below sel among the other enabled rows, wrapping.
   function automatic int ref_move(input int sel, input int en, input bit down);
      int cand[$];
      for (int i = 0; i < NB; i++)
         if (en[i] && i != sel) cand.push_back(i);
      if (cand.size() == 0) return sel;
      if (down) begin
         for (int q = 0; q < cand.size(); q++)
            if (cand[q] > sel) return cand[q];
         return cand[0];
      end
      for (int q = cand.size() - 1; q >= 0; q--)
         if (cand[q] < sel) return cand[q];
      return cand[cand.size() - 1];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  m_sel, m_av, m_ac, n_sel, n_av, n_ac;
      int  en, row, addr, fx, p_row, p_fx, p_sel;
      bit  hit, p_hit, p_anyen, ku, kd, ks, fs, bc;

      rst              = 1'b1;
      bus.frame_start  = 1'b0;
      bus.DrawX        = 10'd548;
      bus.DrawY        = 10'd350;
      bus.if_BetCheck  = 1'b0;
      bus.btn_enable   = 3'b111;
      bus.key_up       = 1'b0;
      bus.key_down     = 1'b0;
      bus.key_select   = 1'b0;
      bus.font_data    = 8'hFF;
      #2;
      chk("rst_sel",   int'(bus.sel_index),    0);
      chk("rst_av",    int'(bus.action_valid), 0);
      chk("rst_ac",    int'(bus.action_code),  0);
      chk("rst_addr",  int'(bus.font_address), 0);
      chk("rst_text",  int'(bus.text_on),      0);
      chk("rst_hl",    int'(bus.highlight_on), 0);
      cyc();
      rst = 1'b0;

      vt[0]  = '{548, 350, 1'b0, 8'h80, 1312, 1'b1, 1'b1};
      vt[1]  = '{540, 351, 1'b1, 8'h80, 1457, 1'b1, 1'b1};
      vt[2]  = '{557, 396, 1'b0, 8'h40, 1488, 1'b1, 1'b0};
      vt[3]  = '{560, 400, 1'b1, 8'h08, 1492, 1'b1, 1'b0};
      vt[4]  = '{572, 442, 1'b0, 8'h7F, 1120, 1'b0, 1'b0};
      vt[5]  = '{611, 457, 1'b1, 8'h01,  527, 1'b1, 1'b0};
      vt[6]  = '{612, 350, 1'b0, 8'hFF,    0, 1'b0, 1'b0};
      vt[7]  = '{539, 350, 1'b0, 8'hFF,    0, 1'b0, 1'b0};
      vt[8]  = '{548, 366, 1'b0, 8'hFF,    0, 1'b0, 1'b0};
      vt[9]  = '{580, 396, 1'b0, 8'hFF, 1040, 1'b1, 1'b0};
      vt[10] = '{580, 350, 1'b1, 8'h00, 1104, 1'b0, 1'b1};
      vt[11] = '{548, 488, 1'b0, 8'hFF,    0, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         bus.DrawX       = 10'(vt[i].x);
         bus.DrawY       = 10'(vt[i].y);
         bus.if_BetCheck = vt[i].bc;
         #2;
         chk($sformatf("tbl%0d_addr", i), int'(bus.font_address), vt[i].addr);
         cyc();
         bus.font_data = vt[i].fd;
         bus.DrawX     = 10'd0;
         bus.DrawY     = 10'd0;
         #2;
         chk($sformatf("tbl%0d_text", i), int'(bus.text_on),      int'(vt[i].txt));
         chk($sformatf("tbl%0d_hl", i),   int'(bus.highlight_on), int'(vt[i].hl));
      end

      bus.if_BetCheck = 1'b0;
      bus.btn_enable  = 3'b101;
      press(0, 1, 0); chk("nav_dn_skip", int'(bus.sel_index), 2);
      press(0, 1, 0); chk("nav_dn_wrap", int'(bus.sel_index), 0);
      press(1, 0, 0); chk("nav_up_wrap", int'(bus.sel_index), 2);

      bus.btn_enable = 3'b111;
      press(0, 1, 0);
      press(0, 1, 0); chk("nav_to1", int'(bus.sel_index), 1);
      bus.if_BetCheck = 1'b1;
      press(0, 0, 1);
      chk("sel_av",  int'(bus.action_valid), 1);
      chk("sel_ac",  int'(bus.action_code),  5);
      cyc(); #2;
      chk("sel_av_one", int'(bus.action_valid), 0);
      bus.btn_enable = 3'b101;
      press(0, 0, 1); chk("sel_dis_av", int'(bus.action_valid), 0);
      cyc(); #2;      chk("sel_dis_av2", int'(bus.action_valid), 0);

      bus.btn_enable = 3'b111;
      press(1, 1, 0); chk("updn_hold", int'(bus.sel_index), 1);
      press(1, 0, 0); chk("up_to0", int'(bus.sel_index), 0);
      press(0, 1, 1);
      chk("selmv_av",  int'(bus.action_valid), 1);
      chk("selmv_ac",  int'(bus.action_code),  4);
      chk("selmv_sel", int'(bus.sel_index),    0);

      press(0, 1, 0);
      bus.btn_enable = 3'b001;
      cyc(); #2;      chk("reval_wait", int'(bus.sel_index), 1);
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      #2;             chk("reval_sel", int'(bus.sel_index), 0);

      bus.btn_enable  = 3'b000;
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      bus.DrawX = 10'd548;
      bus.DrawY = 10'd350;
      #2;             chk("allz_sel", int'(bus.sel_index), 0);
      cyc();
      bus.font_data = 8'h80;
      #2;
      chk("allz_hl",   int'(bus.highlight_on), 0);
      chk("allz_text", int'(bus.text_on),      1);

      bus.if_BetCheck = 1'b0;
      bus.btn_enable  = 3'b111;
      press(1, 0, 0);
      press(0, 0, 1);
      chk("pre_rst_ac", int'(bus.action_code), 2);
      chk("pre_rst_hl", int'(bus.highlight_on), 0);
      rst = 1'b1;
      #1;
      chk("arst_sel",  int'(bus.sel_index),    0);
      chk("arst_av",   int'(bus.action_valid), 0);
      chk("arst_ac",   int'(bus.action_code),  0);
      chk("arst_addr", int'(bus.font_address), 0);
      chk("arst_text", int'(bus.text_on),      0);
      cyc();
      rst = 1'b0;

      m_sel = 0; m_av = 0; m_ac = 0;
      p_hit = 0; p_row = 0; p_fx = 0; p_sel = 0; p_anyen = 1;
      en = 7;
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(15, 0) == 0) en = int'($urandom_range(7, 0));
         bc = 1'($urandom_range(1, 0));
         ku = ($urandom_range(5, 0) == 0);
         kd = ($urandom_range(5, 0) == 0);
         ks = ($urandom_range(5, 0) == 0);
         fs = ($urandom_range(7, 0) == 0);
         bus.btn_enable  = 3'(en);
         bus.if_BetCheck = bc;
         bus.key_up      = ku;
         bus.key_down    = kd;
         bus.key_select  = ks;
         bus.frame_start = fs;
         bus.DrawX       = 10'($urandom_range(640, 520));
         bus.DrawY       = 10'($urandom_range(510, 330));
         bus.font_data   = 8'($urandom);
         #2;
         ref_pixel(int'(bus.DrawX), int'(bus.DrawY), bc, hit, row, addr, fx);
         chk("rnd_addr", int'(bus.font_address), addr);
         chk("rnd_text", int'(bus.text_on), int'(p_hit && bus.font_data[7 - p_fx]));
         chk("rnd_hl",   int'(bus.highlight_on), int'(p_hit && p_row == p_sel && p_anyen));
         chk("rnd_sel",  int'(bus.sel_index),    m_sel);
         chk("rnd_av",   int'(bus.action_valid), m_av);
         chk("rnd_ac",   int'(bus.action_code),  m_ac);

         n_sel = m_sel; n_av = 0; n_ac = m_ac;
         if (ks && en[m_sel]) begin
            n_av = 1;
            n_ac = (int'(bc) << 2) | m_sel;
         end
         if (!ks && ku && !kd)      n_sel = ref_move(m_sel, en, 1'b0);
         else if (!ks && kd && !ku) n_sel = ref_move(m_sel, en, 1'b1);
         else if (fs && !en[m_sel]) n_sel = ref_move(m_sel, en, 1'b1);

         p_hit = hit; p_row = row; p_fx = fx; p_sel = m_sel; p_anyen = (en != 0);
         cyc();
         m_sel = n_sel; m_av = n_av; m_ac = n_ac;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/action_menu_display.md
Name: action_menu_display

Overview:
- Parametrised successor to the fixed three-row action-button text overlay.
- Draws NUM_BUTTONS labelled action rows in the lower-right text panel and handles pipelined (synchronous) font ROM latency.
- Owns a keyboard-driven selection cursor that skips disabled actions and highlights the selected row.
- Issues a one-cycle action strobe to the game FSM on select.

Parameters:
- NUM_BUTTONS, 3, number of action rows (legal 2..4); row 0 is the top row.
- X_START, 540, left pixel column of all labels.
- ROW_Y0, 350, top pixel row of row 0.
- ROW_PITCH, 46, vertical distance between row tops, in pixels (must be at least 16).
- CHARS, 9, characters per label, each 8 px wide.
- FONT_LATENCY, 1, clock cycles from font_address to valid font_data (legal 0..2).

Ports:
- Clk, input, 1, pixel-domain clock.
- Reset, input, 1, asynchronous active-high reset.
- frame_start, input, 1, one-cycle pulse at start of vertical blank.
- DrawX, input, 10, current pixel X.
- DrawY, input, 10, current pixel Y.
- if_BetCheck, input, 1, label mode: 1 = BET/CHECK, 0 = RAISE/CALL.
- btn_enable, input, NUM_BUTTONS, per-row enable; disabled rows are not selectable.
- key_up, input, 1, one-cycle keypress pulse.
- key_down, input, 1, one-cycle keypress pulse.
- key_select, input, 1, one-cycle keypress pulse.
- font_data, input, 8, font ROM row data; MSB is the leftmost pixel.
- font_address, output, 11, font ROM address: char code × 16 + glyph row.
- text_on, output, 1, foreground pixel, aligned FONT_LATENCY cycles after its DrawX/DrawY.
- highlight_on, output, 1, pixel lies in the selected row's box, same alignment as text_on.
- sel_index, output, 2, currently selected row.
- action_valid, output, 1, one-cycle pulse on an accepted select.
- action_code, output, 3, {if_BetCheck, sel_index}, captured with action_valid.

Behaviour:
- Async Reset: sel_index=0, action_valid=0, action_code=0, all pipeline registers cleared, text_on=0, highlight_on=0, font_address=0.
- Label table per row:
  - Row 0: "[B] BET  " when if_BetCheck=1, else "[R] RAISE".
  - Row 1: "[C] CHECK" when if_BetCheck=1, else "[C] CALL ".
  - Row 2: "[F] FOLD ".
  - Row 3: "[A] ALLIN".
  - Characters are ASCII codes.
- Geometry: row r hits when DrawY is in [ROW_Y0+r*ROW_PITCH, +16) and DrawX is in [X_START, X_START+8*CHARS).
  - char = (DrawX−X_START)>>3; glyph row = DrawY−row top.
  - Character index is clamped to 0 if it reaches CHARS or more.
  - Outside every row, font_address=0.
- font_address is combinational from the current DrawX/DrawY.
- Pipeline: the hit flag, font_x (3 bits) and the selected-row flag are delayed FONT_LATENCY stages.
  - text_on = delayed hit AND font_data[7−delayed font_x].
  - highlight_on = delayed hit AND delayed selected flag.
  - With FONT_LATENCY=0, all outputs are purely combinational from the current pixel.
- Navigation, registered on Clk:
  - key_down moves to the next higher enabled index, wrapping NUM_BUTTONS−1→0.
  - key_up moves to the next lower enabled index, wrapping 0→NUM_BUTTONS−1.
  - The search skips disabled rows. If no other enabled row exists, sel_index holds.
- Same-cycle key rules:
  - key_up and key_down together: both ignored.
  - key_select together with a move: select wins, using the pre-move sel_index; no move occurs.
- Select: if btn_enable[sel_index]=1, then next cycle action_valid=1 for exactly one cycle, with action_code={if_BetCheck, sel_index}. A select on a disabled row is ignored.
- Revalidation: on frame_start, if btn_enable[sel_index]=0, sel_index advances as for key_down. If btn_enable is all zero, sel_index holds and highlight_on is forced 0.
- Mid-frame if_BetCheck change: labels switch immediately; no state change.
- sel_index bits above $clog2(NUM_BUTTONS) are 0.

Optional Feature:
- Macro: MENU_BLINK_EN.
- When defined:
  - An internal 5-bit frame counter increments on each frame_start and wraps at 31.
  - While counter[4]=1, highlight_on=0 and the selected row's text_on is inverted within its glyph cells.
  - Any accepted key_up, key_down or key_select clears the counter.
- When undefined: no counter; highlight is steady; text is never inverted.

Test Plan:
- Reset asserted mid-frame with sel_index=2 → all outputs 0 and sel_index=0 immediately (asynchronous), before the next Clk edge.
- FONT_LATENCY=1, DrawX=548, DrawY=350, if_BetCheck=0 → font_address=82×16+0=1312; next cycle font_data=8'h80 gives text_on=1 (font_x=0).
- btn_enable=3'b101, sel_index=0, key_down → sel_index=2; key_down again → wraps to 0; key_up from 0 → 2.
- sel_index=1, key_select with btn_enable=3'b111, if_BetCheck=1 → action_valid high for exactly 1 cycle, action_code=3'b101. Repeat with btn_enable[1]=0 → no pulse.
- key_up and key_down in the same cycle → sel_index unchanged. key_select with key_down at sel_index=0 → action_code LSBs=0, sel_index stays 0.
- sel_index=1, btn_enable changes to 3'b001, then frame_start → sel_index=0. With MENU_BLINK_EN defined, 16 frame_starts → highlight_on=0 on row 0 pixels.
